// File: rtl/hilo_mdu.sv
// Iterative multiply/divide unit owning the HI/LO registers: shift-add multiply, restoring divide.
// Optional build macro MDU_EARLY_OUT_EN lets multiplies exit CALC once the remaining multiplier bits are zero.
module hilo_mdu #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER) + 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t state, state_nx;

  // acc_hi/acc_lo hold {upper product, multiplier} for multiply, {remainder, quotient} for divide.
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic [CW-1:0]    cnt;
  logic             is_mul, sign_q, sign_r;

  logic             op_mul, op_div, op_sgn, op_zdiv;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge, last_iter;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign op_mul  = (op == OP_MULT) || (op == OP_MULTU);
  assign op_div  = (op == OP_DIV)  || (op == OP_DIVU);
  assign op_sgn  = (op == OP_MULT) || (op == OP_DIV);
  assign op_zdiv = op_div && (b == '0);
  assign a_abs   = (op_sgn && a[WIDTH-1]) ? -a : a;
  assign b_abs   = (op_sgn && b[WIDTH-1]) ? -b : b;

  // One multiply step: conditional add into the upper half, then shift {carry,hi,lo} right.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  // One divide step: shift {rem,quot} left, trial-subtract the divisor.
  assign div_sh  = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, opnd};
  assign div_sub = div_sh[WIDTH-1:0] - opnd;

`ifdef MDU_EARLY_OUT_EN
  logic [WIDTH-1:0] mplr_left;
  assign mplr_left = (acc_lo >> 1) & ({WIDTH{1'b1}} >> CW'(cnt + 1'b1));
  assign last_iter = (cnt == CW'(ITER - 1)) || (is_mul && (mplr_left == '0));
  // cnt holds the iterations actually run; the skipped ones are just right shifts.
  assign prod_raw  = {acc_hi, acc_lo} >> (CW'(ITER) - cnt);
`else
  assign last_iter = (cnt == CW'(ITER - 1));
  assign prod_raw  = {acc_hi, acc_lo};
`endif

  assign prod_fix = sign_q ? -prod_raw : prod_raw;
  assign quot_fix = sign_q ? -acc_lo : acc_lo;
  assign rem_fix  = sign_r ? -acc_hi : acc_hi;

  assign busy = (state == S_CALC) || (state == S_FIX);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start && (op_mul || op_div)) state_nx = op_zdiv ? S_DONE : S_CALC;
      S_CALC: if (last_iter) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      dbz    <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      cnt    <= '0;
      is_mul <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end else if (op_zdiv) begin
              dbz <= 1'b1;
            end else if (op_mul || op_div) begin
              dbz    <= 1'b0;
              is_mul <= op_mul;
              sign_q <= op_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
              sign_r <= op_sgn && a[WIDTH-1];
              acc_hi <= '0;
              acc_lo <= op_mul ? b_abs : a_abs;
              opnd   <= op_mul ? a_abs : b_abs;
              cnt    <= '0;
            end
          end
        end
        S_CALC: begin
          if (is_mul) begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end else begin
            acc_hi <= div_ge ? div_sub : div_sh[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          if (is_mul) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else begin
            hi <= rem_fix;
            lo <= quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: directed corner cases plus random ops against an arithmetic model.
module tb_hilo_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  logic [31:0] hi_m = '0, lo_m = '0;
  logic        dbz_m = 1'b0;

  hilo_mdu #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic int bit_len(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  function automatic int exp_latency(input logic [2:0] o, input logic [31:0] y);
    logic [31:0] mag;
    if (o >= 3'd2 && y == 0) return 1;
`ifdef MDU_EARLY_OUT_EN
    if (o <= 3'd1) begin
      mag = (o == 3'd0 && y[31]) ? -y : y;
      return ((bit_len(mag) < 1) ? 1 : bit_len(mag)) + 2;
    end
`endif
    mag = y;
    return 34 + 0 * mag[0];
  endfunction

  // Reference results from plain 64-bit arithmetic.
  task automatic model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, sp;
    logic [63:0] up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin sp = sx * sy; hi_m = sp[63:32]; lo_m = sp[31:0]; dbz_m = 1'b0; end
      3'd1: begin up = {32'd0, x} * {32'd0, y}; hi_m = up[63:32]; lo_m = up[31:0]; dbz_m = 1'b0; end
      3'd2, 3'd3: begin
        if (y == 0) dbz_m = 1'b1;
        else if (o == 3'd2) begin
          sp = sx / sy; lo_m = sp[31:0];
          sp = sx % sy; hi_m = sp[31:0]; dbz_m = 1'b0;
        end else begin
          lo_m = x / y; hi_m = x % y; dbz_m = 1'b0;
        end
      end
      3'd4: hi_m = x;
      3'd5: lo_m = x;
      default: ;
    endcase
  endtask

  // Issues one MULT*/DIV* op and checks latency, busy, stability, results and the done pulse.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int lat, cyc;
    logic [31:0] old_hi, old_lo;
    logic stable, busy_ok;
    old_hi = hi_m; old_lo = lo_m;
    lat = exp_latency(o, y);
    model_op(o, x, y);
    @(negedge clk); start = 1'b1; op = o; a = x; b = y;
    @(negedge clk); start = 1'b0; a = $urandom; b = $urandom;
    cyc = 1; stable = 1'b1; busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (hi !== old_hi || lo !== old_lo) stable = 1'b0;
      @(negedge clk); cyc++;
    end
    total++; if (cyc != lat) begin bad++; $display("FAIL latency op=%0d a=%h b=%h got=%0d exp=%0d", o, x, y, cyc, lat); end
    total++; if (!busy_ok) begin bad++; $display("FAIL busy_in_flight op=%0d a=%h b=%h", o, x, y); end
    total++; if (!stable) begin bad++; $display("FAIL hilo_stable op=%0d a=%h b=%h", o, x, y); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_at_done op=%0d got=%b exp=0", o, busy); end
    total++; if (hi !== hi_m) begin bad++; $display("FAIL hi op=%0d a=%h b=%h got=%h exp=%h", o, x, y, hi, hi_m); end
    total++; if (lo !== lo_m) begin bad++; $display("FAIL lo op=%0d a=%h b=%h got=%h exp=%h", o, x, y, lo, lo_m); end
    total++; if (dbz !== dbz_m) begin bad++; $display("FAIL dbz op=%0d a=%h b=%h got=%b exp=%b", o, x, y, dbz, dbz_m); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle op=%0d got=%b exp=0", o, done); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (hi !== 0 || lo !== 0) begin bad++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo); end
    total++; if (busy !== 0 || done !== 0 || dbz !== 0) begin bad++; $display("FAIL reset_flags got=%b%b%b exp=000", busy, done, dbz); end
    rst = 1'b0;
  endtask

  task automatic test_move;
    logic [2:0]  mops [4] = '{3'd4, 3'd5, 3'd6, 3'd7};
    logic [31:0] mval [4] = '{32'h12345678, 32'h9ABCDEF0, 32'hDEADBEEF, 32'hCAFEF00D};
    for (int i = 0; i < 4; i++) begin
      model_op(mops[i], mval[i], 32'h0);
      @(negedge clk); start = 1'b1; op = mops[i]; a = mval[i]; b = 32'h0;
      @(negedge clk); start = 1'b0;
      total++; if (hi !== hi_m || lo !== lo_m) begin bad++; $display("FAIL move op=%0d got=%h/%h exp=%h/%h", mops[i], hi, lo, hi_m, lo_m); end
      total++; if (busy !== 0 || done !== 0) begin bad++; $display("FAIL move_flags op=%0d busy=%b done=%b exp=0/0", mops[i], busy, done); end
    end
  endtask

  task automatic test_directed;
    logic [2:0]  dop [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd2, 3'd0, 3'd1, 3'd1, 3'd3, 3'd0, 3'd2};
    logic [31:0] da  [12] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'd5, 32'h80000000,
                              32'h80000000, 32'd3, 32'd9, 32'd77, 32'd7, 32'd13};
    logic [31:0] db  [12] = '{32'd5, 32'd5, 32'd2, 32'd7, 32'd0, 32'hFFFFFFFF,
                              32'h80000000, 32'd5, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB};
    for (int i = 0; i < 12; i++) do_op(dop[i], da[i], db[i]);
  endtask

  task automatic test_random;
    logic [31:0] x, y;
    logic [2:0]  o;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = $urandom;
        1: y = $urandom_range(0, 300);
        2: y = 32'($urandom_range(0, 2)) - 32'd1;
        default: y = -32'($urandom_range(1, 50));
      endcase
      do_op(o, x, y);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] x, y;
    int cyc;
    x = $urandom; y = $urandom | 32'h8000_0000;
    model_op(3'd1, x, y);
    @(negedge clk); start = 1'b1; op = 3'd1; a = x; b = y;
    cyc = 0;
    do begin
      @(negedge clk); cyc++; a = $urandom; b = $urandom;
    end while (done !== 1'b1 && cyc < 60);
    total++; if (cyc != 34) begin bad++; $display("FAIL b2b_latency got=%0d exp=34", cyc); end
    total++; if (hi !== hi_m || lo !== lo_m) begin bad++; $display("FAIL b2b_result got=%h/%h exp=%h/%h", hi, lo, hi_m, lo_m); end
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL b2b_requeue busy=%b done=%b exp=0/0", busy, done); end
  endtask

  task automatic test_reset_mid;
    logic seen_done;
    @(negedge clk); start = 1'b1; op = 3'd1; a = 32'hFFFF_0001; b = 32'h8765_4321;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    hi_m = '0; lo_m = '0; dbz_m = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (hi !== 0 || lo !== 0) begin bad++; $display("FAIL midrst_hilo got=%h/%h exp=0/0", hi, lo); end
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0) seen_done = 1'b1;
      @(negedge clk);
    end
    total++; if (seen_done) begin bad++; $display("FAIL midrst_done got=1 exp=0"); end
    do_op(3'd0, 32'hFFFFFFFD, 32'd5);
  endtask

  initial begin
    test_reset;
    test_move;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
